// File: rtl/add_sub_pkg.sv
// -----------------------------------------------------------------------------
// add_sub_pkg
// Shared types and elaboration helpers for the chunk-serial adder/subtractor.
//   state_e  : controller states (IDLE, RUN, DONE)
//   calc_n   : number of CHUNK-bit slices making up a WIDTH-bit operand
//   calc_kw  : width of the slice counter for a given slice count
// -----------------------------------------------------------------------------
package add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Guarded against CHUNK=0 so the top can report its own error instead of
    // tripping over a divide by zero during elaboration.
    function automatic int calc_n(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 0;
    endfunction

    // A one-slice configuration still needs a 1-bit counter.
    function automatic int calc_kw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// -----------------------------------------------------------------------------
// chunk_adder
// Purely combinational CHUNK-bit ripple-carry adder built from full adders.
//   a_i [CHUNK-1:0] : addend slice A
//   b_i [CHUNK-1:0] : addend slice B (already inverted by the caller for sub)
//   c_i             : carry into bit 0
//   s_o [CHUNK-1:0] : sum slice
//   c_o             : carry out of the top bit
// -----------------------------------------------------------------------------
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] s_o,
    output logic             c_o
);

    logic [CHUNK:0] c;

    assign c[0] = c_i;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign c_o = c[CHUNK];

endmodule

// File: rtl/add_sub_seq.sv
// -----------------------------------------------------------------------------
// add_sub_seq
// Sequential WIDTH-bit adder/subtractor that processes CHUNK bits per clock,
// least-significant slice first, through a single shared chunk_adder.
//   i_clk, i_rst_n       : clock, asynchronous active-low reset
//   i_valid / o_ready    : operation handshake (accepted only in IDLE)
//   i_a, i_b             : operands
//   i_sub                : 0 = A+B+c_in, 1 = A-B-borrow_in
//   i_c_in               : carry-in / borrow-in for multiword chaining
//   o_valid / i_ready    : result handshake (held in DONE until taken)
//   o_s                  : sum / difference
//   o_c_out              : carry out of MSB (sub: 1 = no borrow)
//   o_ovf                : signed overflow
//   o_zero               : o_s == 0
// Result latency is exactly N = WIDTH/CHUNK edges after the accepting edge.
// -----------------------------------------------------------------------------
module add_sub_seq
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    input  logic             i_c_in,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_s,
    output logic             o_c_out,
    output logic             o_ovf,
    output logic             o_zero
);

    localparam int          N      = calc_n(WIDTH, CHUNK);
    localparam int          KW     = calc_kw(N);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    if (CHUNK < 1 || WIDTH < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("add_sub_seq: WIDTH must be a positive multiple of CHUNK");
    end

    state_e            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  bx_q, bx_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              c_out_q, c_out_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic [CHUNK-1:0]  sum_chunk;
    logic              cout_chunk;

    // Slice k of the latched operands feeds the shared adder.
    assign a_chunk = a_q[int'(k_q) * CHUNK +: CHUNK];
    assign b_chunk = bx_q[int'(k_q) * CHUNK +: CHUNK];

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a_i (a_chunk),
        .b_i (b_chunk),
        .c_i (carry_q),
        .s_o (sum_chunk),
        .c_o (cout_chunk)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        a_d     = a_q;
        bx_d    = bx_q;
        s_d     = s_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    // Subtraction is A + ~B + 1; a borrow-in of 1 cancels the +1,
                    // hence the carry seed is c_in ^ sub.
                    a_d     = i_a;
                    bx_d    = i_b ^ {WIDTH{i_sub}};
                    carry_d = i_c_in ^ i_sub;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[int'(k_q) * CHUNK +: CHUNK] = sum_chunk;
                carry_d = cout_chunk;
                k_d     = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    // Flags are frozen here from the fully assembled result so
                    // they stay stable for the whole DONE phase.
                    state_d = DONE;
                    k_d     = '0;
                    c_out_d = cout_chunk;
                    zero_d  = (s_d == '0);
                    ovf_d   = (a_q[WIDTH-1] == bx_q[WIDTH-1]) &&
                              (s_d[WIDTH-1] != a_q[WIDTH-1]);
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            bx_q    <= '0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            bx_q    <= bx_d;
            s_q     <= s_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_valid = (state_q == DONE);
    assign o_s     = s_q;
    assign o_c_out = c_out_q;
    assign o_ovf   = ovf_q;
    assign o_zero  = zero_q;

endmodule
